// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite definitions for the single-port initiator and its bench.
// Contents: HTRANS encodings, the fixed word HSIZE, HRESP codes and a command record.
package ahb_lite_pkg;

  localparam int unsigned CMD_ADDR_W = 32;
  localparam int unsigned CMD_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    BUSY   = 2'b01,
    NONSEQ = 2'b10,
    SEQ    = 2'b11
  } htrans_t;

  localparam logic [2:0] HSIZE_WORD  = 3'b010;
  localparam logic       HRESP_OKAY  = 1'b0;
  localparam logic       HRESP_ERROR = 1'b1;

  typedef struct packed {
    logic                  write;
    logic [CMD_ADDR_W-1:0] addr;
    logic [CMD_DATA_W-1:0] wdata;
  } cmd_t;

endpackage

// File: rtl/ahb_lite_master_if.sv
// Bundle of the command/response stream and the AHB-Lite bus of the initiator.
// master modport: the initiator's view (drives cmd_ready, rsp_*, busy and the
// address/data-phase bus signals). slave modport: the opposite side (command
// source plus the AHB slave returning HREADY/HRDATA/HRESP).
interface ahb_lite_master_if #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
);

  // Command stream
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata;

  // Response stream
  logic              rsp_valid;
  logic              rsp_write;
  logic [DATA_W-1:0] rsp_rdata;
  logic              rsp_err;
  logic              busy;

  // AHB-Lite bus
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADY;
  logic [DATA_W-1:0] HRDATA;
  logic              HRESP;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output cmd_ready,
    output rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    input  HREADY, HRDATA, HRESP
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  cmd_ready,
    input  rsp_valid, rsp_write, rsp_rdata, rsp_err, busy,
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA,
    output HREADY, HRDATA, HRESP
  );

endinterface

// File: rtl/ahb_lite_master.sv
// Single-port AHB-Lite initiator: turns a valid/ready command stream into
// single NONSEQ word transfers and returns one response pulse per transfer.
// The next address phase overlaps the current data phase (two slots), so
// back-to-back commands sustain one transfer per cycle with zero wait states.
// Ports:
//   HCLK    - bus clock, rising edge
//   HRESETn - asynchronous active-low reset
//   bus     - command/response stream and AHB-Lite master signals
module ahb_lite_master
  import ahb_lite_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_lite_master_if.master  bus
);

  // Address slot
  logic              a_vld_q;
  logic              a_wr_q;
  logic [ADDR_W-1:0] a_addr_q;
  logic [DATA_W-1:0] a_wdata_q;

  // Data slot
  logic              d_vld_q;
  logic              d_wr_q;
  logic [DATA_W-1:0] d_wdata_q;

  // Held address phase cancelled by the first cycle of an ERROR response
  logic              cxl_q;

  // Response registers
  logic              rsp_valid_q;
  logic              rsp_write_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic issue;
  logic cmd_ready;
  logic accept;
  logic d_done;
  logic unused_addr_lsbs;

  assign issue     = a_vld_q && !cxl_q;
  // Combinational in HREADY so a new command can replace one whose address
  // phase completes this cycle.
  assign cmd_ready = !a_vld_q || (bus.HREADY && !cxl_q);
  assign accept    = bus.cmd_valid && cmd_ready;
  assign d_done    = d_vld_q && bus.HREADY;

  assign unused_addr_lsbs = ^bus.cmd_addr[1:0];

  // Address slot
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      a_vld_q   <= 1'b0;
      a_wr_q    <= 1'b0;
      a_addr_q  <= '0;
      a_wdata_q <= '0;
    end else if (accept) begin
      a_vld_q   <= 1'b1;
      a_wr_q    <= bus.cmd_write;
      a_addr_q  <= {bus.cmd_addr[ADDR_W-1:2], 2'b00};
      a_wdata_q <= bus.cmd_wdata;
    end else if (bus.HREADY && !cxl_q) begin
      a_vld_q   <= 1'b0;
    end
    // A cancelled transfer stays put and reissues once cxl_q drops.
  end

  // Data slot: advances on every completed bus cycle
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      d_vld_q   <= 1'b0;
      d_wr_q    <= 1'b0;
      d_wdata_q <= '0;
    end else if (bus.HREADY) begin
      d_vld_q   <= issue;
      d_wr_q    <= a_wr_q;
      d_wdata_q <= a_wdata_q;
    end
  end

  // Set on the first ERROR cycle so HTRANS is IDLE during the second one,
  // cleared when that second cycle completes.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      cxl_q <= 1'b0;
    end else if (bus.HREADY) begin
      cxl_q <= 1'b0;
    end else if (d_vld_q && (bus.HRESP == HRESP_ERROR)) begin
      cxl_q <= 1'b1;
    end
  end

  // Response capture, one cycle after data-phase completion
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      rsp_valid_q <= 1'b0;
      rsp_write_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      rsp_valid_q <= d_done;
      if (d_done) begin
        rsp_write_q <= d_wr_q;
        rsp_rdata_q <= d_wr_q ? '0 : bus.HRDATA;
        rsp_err_q   <= bus.HRESP;
      end
    end
  end

  always_comb begin
    bus.cmd_ready = cmd_ready;
    bus.busy      = a_vld_q || d_vld_q;
    bus.rsp_valid = rsp_valid_q;
    bus.rsp_write = rsp_write_q;
    bus.rsp_rdata = rsp_rdata_q;
    bus.rsp_err   = rsp_err_q;
    bus.HTRANS    = issue ? NONSEQ : IDLE;
    bus.HSEL      = issue;
    bus.HADDR     = a_addr_q;
    bus.HWRITE    = a_wr_q;
    bus.HSIZE     = HSIZE_WORD;
    bus.HWDATA    = d_vld_q ? d_wdata_q : '0;
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Self-checking bench for ahb_lite_master: a behavioural AHB slave with
// programmable wait states and ERROR responses, plus a response scoreboard.
module tb_ahb_lite_master;
  import ahb_lite_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;

  logic HCLK = 1'b0;
  logic HRESETn = 1'b0;

  ahb_lite_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus_if ();

  ahb_lite_master #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .HCLK    (HCLK),
    .HRESETn (HRESETn),
    .bus     (bus_if.master)
  );

  always #5 HCLK = ~HCLK;

  int n_cmp = 0;
  int n_mis = 0;
  int n_rsp = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- slave model ----------------
  bit [31:0]   mem [64];
  logic        dp_vld;
  logic        dp_wr;
  logic [AW-1:0] dp_addr;
  int unsigned wait_cnt;
  logic [1:0]  err_st;

  bit          ws_rand  = 1'b0;
  int unsigned ws_fixed = 0;
  logic [AW-1:0] ws_addr = '0;
  bit          err_en   = 1'b0;
  logic [AW-1:0] err_addr = '0;
  bit          poke_en  = 1'b0;
  logic [5:0]  poke_idx = '0;
  logic [31:0] poke_data = '0;

  always_comb begin
    if (!dp_vld)          bus_if.HREADY = 1'b1;
    else if (err_st != 0) bus_if.HREADY = (err_st == 2'd2);
    else                  bus_if.HREADY = (wait_cnt == 0);
    bus_if.HRESP  = dp_vld && (err_st != 0);
    bus_if.HRDATA = (dp_vld && !dp_wr) ? mem[dp_addr[7:2]] : '0;
  end

  always @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      dp_vld   <= 1'b0;
      dp_wr    <= 1'b0;
      dp_addr  <= '0;
      wait_cnt <= 0;
      err_st   <= 2'd0;
    end else if (bus_if.HREADY) begin
      dp_vld   <= bus_if.HSEL && (bus_if.HTRANS == NONSEQ);
      dp_wr    <= bus_if.HWRITE;
      dp_addr  <= bus_if.HADDR;
      wait_cnt <= ws_rand ? $urandom_range(0, 2) : ((bus_if.HADDR == ws_addr) ? ws_fixed : 0);
      err_st   <= (err_en && bus_if.HADDR == err_addr && bus_if.HTRANS == NONSEQ) ? 2'd1 : 2'd0;
    end else if (err_st == 2'd1) begin
      err_st <= 2'd2;
    end else if (wait_cnt != 0) begin
      wait_cnt <= wait_cnt - 1;
    end
  end

  always @(posedge HCLK) begin
    if (poke_en) mem[poke_idx] <= poke_data;
    else if (HRESETn && dp_vld && dp_wr && bus_if.HREADY && err_st == 2'd0)
      mem[dp_addr[7:2]] <= bus_if.HWDATA;
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        wr;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t      exp_q[$];
  bit [31:0] model_mem [64];

  always @(negedge HCLK) begin
    exp_t e;
    if (HRESETn && bus_if.rsp_valid) begin
      n_rsp++;
      if (exp_q.size() == 0) begin
        check_eq("rsp_unexpected", 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check_eq("rsp_write", 32'(bus_if.rsp_write), 32'(e.wr));
        check_eq("rsp_rdata", bus_if.rsp_rdata, e.rdata);
        check_eq("rsp_err", 32'(bus_if.rsp_err), 32'(e.err));
      end
    end
  end

  // Returns at acceptance edge + 1.
  task automatic send_cmd(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
    exp_t        e;
    int unsigned cyc;
    logic        rdy;
    bus_if.cmd_valid = 1'b1;
    bus_if.cmd_write = wr;
    bus_if.cmd_addr  = addr;
    bus_if.cmd_wdata = wdata;
    cyc = 0;
    rdy = 1'b0;
    while (!rdy && cyc < 50) begin
      @(negedge HCLK);
      rdy = bus_if.cmd_ready;
      @(posedge HCLK);
      cyc++;
    end
    #1;
    bus_if.cmd_valid = 1'b0;
    if (!rdy) begin
      check_eq("cmd_accept", 32'(rdy), 32'd1);
      return;
    end
    e.wr    = wr;
    e.err   = err_en && ({addr[31:2], 2'b00} == err_addr);
    e.rdata = wr ? 32'd0 : model_mem[addr[7:2]];
    if (wr && !e.err) model_mem[addr[7:2]] = wdata;
    exp_q.push_back(e);
  endtask

  task automatic poke(input logic [5:0] idx, input logic [31:0] data);
    poke_idx  = idx;
    poke_data = data;
    poke_en   = 1'b1;
    model_mem[idx] = data;
    @(posedge HCLK);
    #1;
    poke_en = 1'b0;
  endtask

  task automatic drain();
    int unsigned c = 0;
    while ((exp_q.size() != 0 || bus_if.busy) && c < 200) begin
      @(posedge HCLK);
      #1;
      c++;
    end
    check_eq("drain", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic        wr;
    logic [31:0] addr;
    bus_if.cmd_valid = 1'b0;
    bus_if.cmd_write = 1'b0;
    bus_if.cmd_addr  = '0;
    bus_if.cmd_wdata = '0;

    // Reset values
    #1;
    check_eq("rst_htrans", 32'(bus_if.HTRANS), 32'(IDLE));
    check_eq("rst_hsel", 32'(bus_if.HSEL), 32'd0);
    check_eq("rst_hwrite", 32'(bus_if.HWRITE), 32'd0);
    check_eq("rst_haddr", bus_if.HADDR, 32'd0);
    check_eq("rst_hwdata", bus_if.HWDATA, 32'd0);
    check_eq("rst_hsize", 32'(bus_if.HSIZE), 32'd2);
    check_eq("rst_busy", 32'(bus_if.busy), 32'd0);
    check_eq("rst_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("rst_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK);
    #1;

    // Single write, zero wait states
    send_cmd(1'b1, 32'h4, 32'hA5A5_A5A5);
    check_eq("t1_htrans", 32'(bus_if.HTRANS), 32'(NONSEQ));
    check_eq("t1_hsel", 32'(bus_if.HSEL), 32'd1);
    check_eq("t1_hwrite", 32'(bus_if.HWRITE), 32'd1);
    check_eq("t1_haddr", bus_if.HADDR, 32'h4);
    @(posedge HCLK); #1;
    check_eq("t1_hwdata", bus_if.HWDATA, 32'hA5A5_A5A5);
    @(posedge HCLK); #1;
    check_eq("t1_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    drain();

    // Back-to-back write then read
    poke(6'd1, 32'h1234_5678);
    send_cmd(1'b1, 32'h0, 32'h0000_00FF);
    check_eq("t2_htrans_wr", 32'(bus_if.HTRANS), 32'(NONSEQ));
    send_cmd(1'b0, 32'h4, 32'h0);
    check_eq("t2_htrans_rd", 32'(bus_if.HTRANS), 32'(NONSEQ));
    check_eq("t2_haddr_rd", bus_if.HADDR, 32'h4);
    check_eq("t2_hwrite_rd", 32'(bus_if.HWRITE), 32'd0);
    check_eq("t2_hwdata_wr", bus_if.HWDATA, 32'h0000_00FF);
    drain();

    // Read with 3 wait states, write queued behind it
    ws_addr  = 32'h10;
    ws_fixed = 3;
    send_cmd(1'b0, 32'h10, 32'h0);
    send_cmd(1'b1, 32'h14, 32'hDEAD_BEEF);
    for (int i = 0; i < 3; i++) begin
      check_eq("t3_htrans", 32'(bus_if.HTRANS), 32'(NONSEQ));
      check_eq("t3_haddr", bus_if.HADDR, 32'h14);
      check_eq("t3_hwrite", 32'(bus_if.HWRITE), 32'd1);
      check_eq("t3_cmd_ready", 32'(bus_if.cmd_ready), 32'd0);
      @(posedge HCLK); #1;
    end
    check_eq("t3_rsp_early", 32'(bus_if.rsp_valid), 32'd0);
    @(posedge HCLK); #1;
    check_eq("t3_rsp_valid", 32'(bus_if.rsp_valid), 32'd1);
    drain();
    ws_fixed = 0;

    // ERROR on a read with a write queued behind it
    err_addr = 32'h8;
    err_en   = 1'b1;
    send_cmd(1'b0, 32'h8, 32'h0);
    send_cmd(1'b1, 32'h18, 32'h5555_AAAA);
    check_eq("t4_htrans_err1", 32'(bus_if.HTRANS), 32'(NONSEQ));
    @(posedge HCLK); #1;
    check_eq("t4_htrans_err2", 32'(bus_if.HTRANS), 32'(IDLE));
    check_eq("t4_hsel_err2", 32'(bus_if.HSEL), 32'd0);
    @(posedge HCLK); #1;
    check_eq("t4_htrans_reissue", 32'(bus_if.HTRANS), 32'(NONSEQ));
    check_eq("t4_haddr_reissue", bus_if.HADDR, 32'h18);
    check_eq("t4_rsp_err", 32'(bus_if.rsp_err), 32'd1);
    drain();
    err_en = 1'b0;

    // Reset during the data phase of a write
    send_cmd(1'b1, 32'h1C, 32'h0BAD_CAFE);
    @(posedge HCLK); #1;
    check_eq("t5_hwdata", bus_if.HWDATA, 32'h0BAD_CAFE);
    #2 HRESETn = 1'b0;
    #1;
    check_eq("t5_htrans", 32'(bus_if.HTRANS), 32'(IDLE));
    check_eq("t5_hsel", 32'(bus_if.HSEL), 32'd0);
    check_eq("t5_haddr", bus_if.HADDR, 32'd0);
    check_eq("t5_hwdata_rst", bus_if.HWDATA, 32'd0);
    check_eq("t5_busy", 32'(bus_if.busy), 32'd0);
    check_eq("t5_rsp_valid", 32'(bus_if.rsp_valid), 32'd0);
    check_eq("t5_cmd_ready", 32'(bus_if.cmd_ready), 32'd1);
    // The aborted write never reaches the slave.
    exp_q.delete();
    model_mem[7] = 32'd0;
    repeat (2) @(posedge HCLK);
    #2 HRESETn = 1'b1;
    @(posedge HCLK); #1;
    check_eq("t5_cmd_ready_rel", 32'(bus_if.cmd_ready), 32'd1);
    base = n_rsp;
    poke(6'd3, 32'hCAFE_F00D);
    send_cmd(1'b0, 32'hC, 32'h0);
    drain();
    check_eq("t5_rsp_count", 32'(n_rsp - base), 32'd1);

    // Random back-to-back traffic with random wait states
    ws_rand = 1'b1;
    base = n_rsp;
    for (int i = 0; i < 16; i++) begin
      wr   = 1'($urandom_range(0, 1));
      addr = 32'h40 + 32'(4 * $urandom_range(0, 15));
      send_cmd(wr, addr, $urandom);
    end
    drain();
    check_eq("t6_rsp_count", 32'(n_rsp - base), 32'd16);
    ws_rand = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
- Single-port AHB-Lite initiator that turns a valid/ready command stream into single NONSEQ word transfers.
- Drives the same bus the AHBGPIO slave responds on, with a command-side response stream back to the test or CPU-side logic.
- Overlaps the next address phase with the current data phase, so back-to-back commands sustain one transfer per cycle with zero wait states.
- Supports slave wait states and the two-cycle HRESP error response.

Parameters:
- ADDR_W, 32, HADDR and cmd_addr width.
- DATA_W, 32, HWDATA/HRDATA/cmd_wdata/rsp_rdata width; word transfers only.

Ports:
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESETn  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command offered.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready at clock edge.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  ADDR_W  byte address; bits [1:0] ignored and driven 0 on HADDR.
- cmd_wdata  in  DATA_W  write data.
- rsp_valid  out  1  one-cycle pulse per completed transfer.
- rsp_write  out  1  type of the completed transfer.
- rsp_rdata  out  DATA_W  read data; 0 for writes.
- rsp_err  out  1  transfer ended with HRESP error.
- busy  out  1  address or data phase outstanding.
- HSEL  out  1  high whenever HTRANS = NONSEQ.
- HADDR  out  ADDR_W  address-phase address.
- HTRANS  out  2  2'b00 IDLE, 2'b10 NONSEQ; never BUSY or SEQ.
- HWRITE  out  1  address-phase direction.
- HSIZE  out  3  constant 3'b010.
- HWDATA  out  DATA_W  data-phase write data.
- HREADY  in  1  transfer-complete/bus-ready from slave.
- HRDATA  in  DATA_W  read data.
- HRESP  in  1  0 OKAY, 1 ERROR.

Behaviour:
- State:
  - address slot: a_vld, a_wr, a_addr, a_wdata.
  - data slot: d_vld, d_wr, d_wdata.
  - cancel flag: cxl.
  - response registers.
- Reset (asynchronous): every register 0. Resulting outputs:
  - HTRANS = IDLE; HSEL, HWRITE, busy, rsp_* = 0.
  - HADDR and HWDATA = 0; HSIZE = 3'b010.
  - cmd_ready = 1.
- Reset mid-transfer: both slots dropped and no response is produced. Deassertion is synchronised by the system.
- cmd_ready = !a_vld || (HREADY && !cxl). This is combinational in HREADY, so a command can be accepted in the cycle the current address phase completes.
- Address outputs:
  - HTRANS = NONSEQ iff a_vld && !cxl.
  - HADDR, HWRITE and HSEL are held stable from acceptance until HREADY = 1.
- On each edge with HREADY = 1, the data slot is loaded from the address slot. If a_vld && !cxl, that transfer moves into the data phase; otherwise d_vld <= 0.
- Address slot update on the same edge:
  - Accepted command: loaded into the address slot.
  - No new command and the held transfer was cancelled (cxl): the held transfer stays in the address slot and reissues next cycle.
  - Otherwise: a_vld <= 0.
- HWDATA = d_wdata throughout the data phase; 0 when !d_vld.
- Data-phase completion is d_vld && HREADY. On the next cycle:
  - rsp_valid pulses for one cycle.
  - rsp_write = d_wr; rsp_rdata = HRDATA if read, else 0; rsp_err = HRESP.
  - Latency: command accepted at edge N, zero wait states → rsp_valid high in cycle N+2.
- Error handling:
  - First error cycle (d_vld && HRESP && !HREADY): set cxl, so the next-cycle HTRANS is IDLE.
  - cxl clears when the second error cycle (HREADY = 1) completes.
  - The held command is not lost; it reissues after the error response.
- Wait states (HREADY = 0): all slots hold; cmd_ready = 0 if a_vld.
- Ordering: responses are returned strictly in command order, at most two transfers outstanding.
- busy = a_vld || d_vld.

Decomposition:
- Package ahb_lite_pkg holds:
  - htrans_t enum: IDLE 2'b00, BUSY 2'b01, NONSEQ 2'b10, SEQ 2'b11.
  - HSIZE_WORD = 3'b010.
  - HRESP_OKAY/HRESP_ERROR constants.
  - cmd_t struct (write, addr, wdata).
- No sub-module; address and data slots are kept in one module.

Test Plan:
- Single write to 0x0000_0004, data 0xA5A5_A5A5, HREADY tied 1:
  - Cycle 1: HTRANS = 2'b10, HWRITE = 1, HADDR = 0x4.
  - Cycle 2: HWDATA = 0xA5A5_A5A5.
  - Cycle 3: rsp_valid = 1, rsp_err = 0.
- Back-to-back write to 0x0 (0x0000_00FF) then read of 0x4, slave returns 0x1234_5678:
  - HTRANS NONSEQ on two consecutive cycles.
  - Read address is presented while the write data is on HWDATA.
  - Two rsp pulses in order; second has rsp_rdata = 0x1234_5678.
- Read with HREADY low for 3 cycles in the data phase, plus a queued write:
  - HADDR/HTRANS of the queued write stay stable all 3 cycles; cmd_ready = 0.
  - rsp arrives 1 cycle after HREADY rises.
- Error on a read of 0x8 with a write queued behind it:
  - Error cycle 1 (HRESP = 1, HREADY = 0) → HTRANS = IDLE next cycle.
  - Read response has rsp_err = 1.
  - Queued write reissues as NONSEQ afterwards and completes with rsp_err = 0.
- HRESETn pulled low during the data phase of a write:
  - All outputs go to reset values immediately with no clock edge.
  - No rsp_valid is produced.
  - After release, cmd_ready = 1 and a new read to 0xC completes normally.
- 16 random back-to-back commands with random wait states (HRESP = 0):
  - Response count = 16, in order.
  - Read data matches a scoreboard of the slave memory model.
